lsu_byte_ctrl: RTL

- Load/store unit between the CPU datapath and the word-only data memory (clk, we, a, wd, rd; combinational read, write on posedge clk).
- Adds byte and halfword loads and stores, optional sign extension, and alignment/range fault detection.
- Sub-word stores use a two-cycle read-modify-write. The CPU stalls on req_ready=0.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/byte_lane_mux.sv | 53 +++++
 rtl/lsu_byte_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and defaults for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

  localparam int DEFAULT_DEPTH_WORDS = 64;

endpackage

// File: rtl/byte_lane_mux.sv
// rtl/byte_lane_mux.sv - little-endian lane extract/extend for loads and lane merge for stores
module byte_lane_mux (
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  lane,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);
  import lsu_pkg::*;

  size_e       sz;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign sz = size_e'(size);

  always_comb begin
    case (lane)
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    case (sz)
      SZ_BYTE: ld_data = {{24{sign_ext & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{sign_ext & ld_half[15]}}, ld_half};
      default: ld_data = rd_word;
    endcase

    // Untouched lanes keep the word just read from memory.
    st_word = rd_word;
    case (sz)
      SZ_BYTE: begin
        case (lane)
          2'd0:    st_word[7:0]   = wdata[7:0];
          2'd1:    st_word[15:8]  = wdata[7:0];
          2'd2:    st_word[23:16] = wdata[7:0];
          default: st_word[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) st_word[31:16] = wdata[15:0];
        else         st_word[15:0]  = wdata[15:0];
      end
      default: st_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_byte_ctrl.sv
// rtl/lsu_byte_ctrl.sv - byte/half/word load-store unit with read-modify-write sub-word stores
module lsu_byte_ctrl #(
  parameter int DEPTH_WORDS = lsu_pkg::DEFAULT_DEPTH_WORDS,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_fault,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
);
  import lsu_pkg::*;

  localparam logic [AW:0] ADDR_LIMIT = (AW+1)'(4 * DEPTH_WORDS);

  state_e        state_q, state_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_fault_q, rsp_fault_d;
  logic [31:0]   merge_q, merge_d;
  logic [AW-1:0] addr_q, addr_d;

  size_e         req_sz;
  logic          accept;
  logic          fault;
  logic [AW-1:0] word_addr;
  logic [31:0]   ld_data;
  logic [31:0]   st_word;

  assign req_sz    = size_e'(req_size);
  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready && !reset;
  assign word_addr = {req_addr[AW-1:2], 2'b00};
  assign fault     = (req_sz == SZ_BAD)
                  || (req_sz == SZ_HALF && req_addr[0])
                  || (req_sz == SZ_WORD && req_addr[1:0] != 2'b00)
                  || ({1'b0, req_addr} >= ADDR_LIMIT);

  byte_lane_mux u_lane_mux (
    .size     (req_size),
    .sign_ext (req_signed),
    .lane     (req_addr[1:0]),
    .rd_word  (mem_rd),
    .wdata    (req_wdata),
    .ld_data  (ld_data),
    .st_word  (st_word)
  );

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_fault_d = 1'b0;
    merge_d     = merge_q;
    addr_d      = addr_q;
    mem_we      = 1'b0;
    mem_a       = word_addr;
    mem_wd      = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (fault) begin
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
          end else if (!req_we) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = ld_data;
          end else if (req_sz == SZ_WORD) begin
            mem_we      = 1'b1;
            mem_wd      = req_wdata;
            rsp_valid_d = 1'b1;
          end else begin
            merge_d = st_word;
            addr_d  = word_addr;
            state_d = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        mem_we      = 1'b1;
        mem_a       = addr_q;
        mem_wd      = merge_q;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A reset landing on the write cycle must keep the merged word out of memory.
    if (reset) begin
      mem_we = 1'b0;
      mem_wd = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
      merge_q     <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
      merge_q     <= merge_d;
      addr_q      <= addr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;

endmodule
